// File: rtl/fir_stream_if.sv
// Streaming FIR bus: sample input handshake, result output handshake,
// coefficient write port and synchronous flush.
interface fir_stream_if #(
  parameter int unsigned DW   = 4,
  parameter int unsigned CW   = 4,
  parameter int unsigned TAPS = 4,
  parameter int unsigned OW   = 10
);
  localparam int unsigned AW = $clog2(TAPS);

  logic          clr;
  logic [DW-1:0] x;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] q;
  logic          out_valid;
  logic          out_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_data;

  modport master (
    output clr, x, in_valid, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, q, out_valid
  );

  modport slave (
    input  clr, x, in_valid, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, q, out_valid
  );
endinterface

// File: rtl/fir_stream.sv
// Unsigned streaming FIR with writable coefficients: S1 holds the per-tap
// products of the freshly shifted delay line, S2 holds the clamped sum.
module fir_stream #(
  parameter int unsigned DW   = 4,
  parameter int unsigned CW   = 4,
  parameter int unsigned TAPS = 4,
  parameter int unsigned OW   = 10
) (
  input logic        clk,
  input logic        rst,
  fir_stream_if.slave bus
);
  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned PW = DW + CW;
  localparam int unsigned FW = DW + CW + AW;

  logic [DW-1:0] r_dl   [TAPS];
  logic [CW-1:0] r_coef [TAPS];
  logic [PW-1:0] r_prod [TAPS];
  logic          r_v1;
  logic          r_v2;
  logic [OW-1:0] r_q;

  logic          w_advance;
  logic          w_coef_hit;
  logic [DW-1:0] w_dl_nxt [TAPS];
  logic [FW-1:0] w_sum;
  logic [OW-1:0] w_sat;

  // The whole pipeline freezes only when a result sits unconsumed in S2.
  assign w_advance  = !(r_v2 && !bus.out_ready);
  assign w_coef_hit = bus.coef_we && (32'(bus.coef_addr) < TAPS);

  assign bus.in_ready  = w_advance;
  assign bus.q         = r_q;
  assign bus.out_valid = r_v2;

  always_comb begin
    w_dl_nxt[0] = bus.x;
    for (int unsigned k = 1; k < TAPS; k++) begin
      w_dl_nxt[k] = r_dl[k-1];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      w_sum = w_sum + FW'(r_prod[k]);
    end
  end

  if (OW >= FW) begin : g_ext
    assign w_sat = OW'(w_sum);
  end else begin : g_clamp
    assign w_sat = (|w_sum[FW-1:OW]) ? '1 : w_sum[OW-1:0];
  end

  // Coefficients reset to 1 so an unconfigured filter is a moving sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_coef[k] <= CW'(1);
      end
    end else if (w_coef_hit) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Products sample r_coef before this edge's write lands, so a sample taking
  // the same edge as a coefficient write sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_dl[k]   <= '0;
        r_prod[k] <= '0;
      end
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_q  <= '0;
    end else if (bus.clr) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_dl[k] <= '0;
      end
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (w_advance) begin
      if (bus.in_valid) begin
        for (int unsigned k = 0; k < TAPS; k++) begin
          r_dl[k]   <= w_dl_nxt[k];
          r_prod[k] <= PW'(w_dl_nxt[k]) * PW'(r_coef[k]);
        end
      end
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
      if (r_v1) begin
        r_q <= w_sat;
      end
    end
  end
endmodule

// File: tb/tb_fir_stream.sv
// Directed bench for fir_stream: default, saturating (OW=6) and TAPS=3 builds.
module tb_fir_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fir_stream_if #(.DW(4), .CW(4), .TAPS(4), .OW(10)) b0 ();
  fir_stream_if #(.DW(4), .CW(4), .TAPS(4), .OW(6))  b1 ();
  fir_stream_if #(.DW(4), .CW(4), .TAPS(3), .OW(10)) b2 ();

  fir_stream #(.DW(4), .CW(4), .TAPS(4), .OW(10)) u_dut (.clk(clk), .rst(rst), .bus(b0));
  fir_stream #(.DW(4), .CW(4), .TAPS(4), .OW(6))  u_sat (.clk(clk), .rst(rst), .bus(b1));
  fir_stream #(.DW(4), .CW(4), .TAPS(3), .OW(10)) u_t3  (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic       cl;
    logic       we;
    logic [1:0] ad;
    logic [3:0] da;
    logic       v;
    logic [3:0] x;
    logic       ordy;
    logic       e_ov;
    logic       c_q;
    logic [9:0] e_q;
    logic       e_ir;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic cl, input logic we, input logic [1:0] ad, input logic [3:0] da,
                     input logic v, input logic [3:0] x, input logic ordy, input logic e_ov,
                     input logic c_q, input logic [9:0] e_q, input logic e_ir);
    vec_t t;
    t.cl = cl; t.we = we; t.ad = ad; t.da = da; t.v = v; t.x = x; t.ordy = ordy;
    t.e_ov = e_ov; t.c_q = c_q; t.e_q = e_q; t.e_ir = e_ir;
    tv.push_back(t);
  endtask

  // Drive b0 for one cycle and check its outputs before the next rising edge.
  task automatic step0(input string nm, input logic v, input logic [3:0] x, input logic e_ov,
                       input logic c_q, input logic [9:0] e_q);
    @(negedge clk);
    b0.in_valid = v; b0.x = x; b0.out_ready = 1'b1;
    #1;
    chk({nm, "_ov"}, 32'(b0.out_valid), 32'(e_ov));
    if (c_q) chk({nm, "_q"}, 32'(b0.q), 32'(e_q));
  endtask

  initial begin
    b0.clr = 0; b0.x = 0; b0.in_valid = 0; b0.out_ready = 1;
    b0.coef_we = 0; b0.coef_addr = 0; b0.coef_data = 0;
    b1.clr = 0; b1.x = 0; b1.in_valid = 0; b1.out_ready = 1;
    b1.coef_we = 0; b1.coef_addr = 0; b1.coef_data = 0;
    b2.clr = 0; b2.x = 0; b2.in_valid = 0; b2.out_ready = 1;
    b2.coef_we = 0; b2.coef_addr = 0; b2.coef_data = 0;

    // Moving sum 1,2,3,4,0 -> 1,3,6,10,9, then a 5-cycle stall mid-stream.
    add(0,0,0,0, 1,1,1, 0,0,0,  1);
    add(0,0,0,0, 1,2,1, 0,0,0,  1);
    add(0,0,0,0, 1,3,1, 1,1,1,  1);
    add(0,0,0,0, 1,4,1, 1,1,3,  1);
    add(0,0,0,0, 1,0,1, 1,1,6,  1);
    add(0,0,0,0, 0,0,1, 1,1,10, 1);
    add(0,0,0,0, 0,0,1, 1,1,9,  1);
    add(0,0,0,0, 0,0,1, 0,0,0,  1);
    add(0,0,0,0, 1,5,1, 0,0,0,  1);
    add(0,0,0,0, 1,6,1, 0,0,0,  1);
    for (int i = 0; i < 5; i++) add(0,0,0,0, 1,7,0, 1,1,12, 0);
    add(0,0,0,0, 1,7,1, 1,1,12, 1);
    add(0,0,0,0, 0,0,1, 1,1,15, 1);
    add(0,0,0,0, 0,0,1, 1,1,18, 1);
    add(0,0,0,0, 0,0,1, 0,0,0,  1);
    // clr with a sample offered, coefficients {1,2,3,4}, then impulse.
    add(1,1,0,1, 1,9,1, 0,0,0,  1);
    add(0,1,1,2, 0,0,1, 0,0,0,  1);
    add(0,1,2,3, 0,0,1, 0,0,0,  1);
    add(0,1,3,4, 1,1,1, 0,0,0,  1);
    add(0,0,0,0, 1,0,1, 0,0,0,  1);
    add(0,0,0,0, 1,0,1, 1,1,1,  1);
    add(0,0,0,0, 1,0,1, 1,1,2,  1);
    add(0,0,0,0, 1,0,1, 1,1,3,  1);
    add(0,0,0,0, 0,0,1, 1,1,4,  1);
    add(0,0,0,0, 0,0,1, 1,1,0,  1);
    add(0,0,0,0, 0,0,1, 0,0,0,  1);
    // c[0]<=5 on the same edge as x=1: that sample still uses c[0]=1.
    add(0,1,0,5, 1,1,1, 0,0,0,  1);
    add(0,0,0,0, 1,1,1, 0,0,0,  1);
    add(0,0,0,0, 0,0,1, 1,1,1,  1);
    add(0,0,0,0, 0,0,1, 1,1,7,  1);
    add(0,0,0,0, 0,0,1, 0,0,0,  1);

    #12;
    chk("rst_q", 32'(b0.q), 0);
    chk("rst_ov", 32'(b0.out_valid), 0);
    chk("rst_ir", 32'(b0.in_ready), 1);
    chk("rst_sat_ov", 32'(b1.out_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      b0.clr = tv[i].cl; b0.coef_we = tv[i].we; b0.coef_addr = tv[i].ad;
      b0.coef_data = tv[i].da; b0.in_valid = tv[i].v; b0.x = tv[i].x;
      b0.out_ready = tv[i].ordy;
      #1;
      chk($sformatf("tv%0d_ov", i), 32'(b0.out_valid), 32'(tv[i].e_ov));
      chk($sformatf("tv%0d_ir", i), 32'(b0.in_ready), 32'(tv[i].e_ir));
      if (tv[i].c_q) chk($sformatf("tv%0d_q", i), 32'(b0.q), 32'(tv[i].e_q));
    end
    @(negedge clk);
    b0.clr = 0; b0.coef_we = 0; b0.in_valid = 0; b0.out_ready = 1;

    // OW=6: all c=15, x=15 streamed; every sum (225 upward) clamps to 63.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b1.coef_we = 1; b1.coef_addr = 2'(k); b1.coef_data = 15;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b1.coef_we = 0; b1.in_valid = (i < 6); b1.x = 15;
      #1;
      if (i >= 2 && i < 8) begin
        chk($sformatf("sat%0d_ov", i), 32'(b1.out_valid), 1);
        chk($sformatf("sat%0d_q", i), 32'(b1.q), 63);
      end
    end
    chk("sat_end_ov", 32'(b1.out_valid), 0);

    // TAPS=3: clr under stall with a sample offered and a write to addr 3.
    @(negedge clk); b2.in_valid = 1; b2.x = 2;
    @(negedge clk); b2.x = 3;
    @(negedge clk);
    b2.x = 7; b2.clr = 1; b2.out_ready = 0;
    b2.coef_we = 1; b2.coef_addr = 3; b2.coef_data = 9;
    #1;
    chk("t3_pre_ov", 32'(b2.out_valid), 1);
    chk("t3_pre_q", 32'(b2.q), 2);
    chk("t3_pre_ir", 32'(b2.in_ready), 0);
    @(negedge clk);
    b2.clr = 0; b2.out_ready = 1; b2.coef_we = 0; b2.x = 1;
    #1;
    chk("t3_clr_ov", 32'(b2.out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b2.in_valid = (i < 3); b2.x = 0;
      #1;
      if (i == 0) chk("t3_a_ov", 32'(b2.out_valid), 0);
      if (i >= 1 && i <= 3) chk($sformatf("t3_q%0d", i), 32'(b2.q), 1);
      if (i == 4) chk("t3_q4", 32'(b2.q), 0);
      if (i == 5) chk("t3_end_ov", 32'(b2.out_valid), 0);
    end

    // Reset with two samples in flight, then 2,2 -> 2,4.
    step0("pre_a", 1, 3, 0, 0, 0);
    step0("pre_b", 1, 3, 0, 0, 0);
    @(negedge clk);
    b0.in_valid = 0;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(b0.out_valid), 0);
    chk("mid_rst_q", 32'(b0.q), 0);
    chk("mid_rst_ir", 32'(b0.in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    step0("post_a", 1, 2, 0, 0, 0);
    step0("post_b", 1, 2, 0, 0, 0);
    step0("post_c", 0, 0, 1, 1, 2);
    step0("post_d", 0, 0, 1, 1, 4);
    step0("post_e", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_stream.md
FIR_STREAM -- requirements
Module: fir_stream

Interface
REQ-001 SHALL have parameter DW, default 4, meaning input sample width in bits, unsigned.
REQ-002 SHALL have parameter CW, default 4, meaning coefficient width in bits, unsigned.
REQ-003 SHALL have parameter TAPS, default 4, meaning number of taps (legal range 2..32).
REQ-004 SHALL have parameter OW, default 10, meaning output width in bits.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port clr, input, 1 bit: synchronous flush of the datapath.
REQ-008 SHALL have port x, input, DW bits: input sample.
REQ-009 SHALL have port in_valid, input, 1 bit: x is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts x this cycle.
REQ-011 SHALL have port q, output, OW bits: filter output.
REQ-012 SHALL have port out_valid, output, 1 bit: q is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the downstream consumes q.
REQ-014 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-015 SHALL have port coef_addr, input, clog2(TAPS) bits: coefficient index k.
REQ-016 SHALL have port coef_data, input, CW bits: coefficient value.

Function
REQ-017 SHALL compute y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k], with x[n-k] taken as 0 before the first accepted sample since reset or clr.
REQ-018 SHALL define full width FW = DW+CW+clog2(TAPS); the internal sum is exact at FW bits.
REQ-019 SHALL, when OW>=FW, zero-extend the sum to q; when OW<FW, saturate q to 2^OW-1 whenever the sum exceeds that value.
REQ-020 SHALL accept a sample on a rising edge only when in_valid=1 and in_ready=1 (handshake).
REQ-021 SHALL shift the delay line only on accepted samples; idle cycles do not insert zeros.
REQ-022 SHALL use a two-stage pipeline: S1 registers the updated delay line products; S2 registers the saturated sum into q.
REQ-023 SHALL give a latency of exactly 2 edges: a sample accepted at edge E raises out_valid after edge E+2 when there is no stall.
REQ-024 SHALL define advance = !(out_valid && !out_ready); the pipeline moves only when advance=1, and in_ready = advance.
REQ-025 SHALL keep q and out_valid stable while out_valid=1 and out_ready=0, and lose no sample under stall.
REQ-026 SHALL sustain 1 sample per cycle when in_valid=1 and out_ready=1 continuously.
REQ-027 SHALL write coef_data into c[coef_addr] on an edge with coef_we=1; the write is independent of the handshake and of stalls.
REQ-028 SHALL ignore coefficient writes with coef_addr>=TAPS.
REQ-029 SHALL use, for a sample accepted at the same edge as a coefficient write, the old coefficient; the new value applies from the next accepted sample.
REQ-030 SHALL, on clr=1, zero the delay line and the S1/S2 valid bits on the edge and take no sample that cycle; coefficients are retained.
REQ-031 SHALL give clr priority over a simultaneous handshake and over a stall.

Reset
REQ-032 SHALL, while rst=0, asynchronously force the delay line to 0, all valid bits to 0, q=0, out_valid=0, and in_ready=1.
REQ-033 SHALL reset every coefficient c[k] to 1, so the reset filter is a TAPS-point moving sum.
REQ-034 SHALL discard in-flight samples when reset is asserted mid-operation; the first output after release reflects only post-reset samples.

Verification
REQ-035 SHALL cover default parameters, reset coefficients, inputs 1,2,3,4,0 on consecutive cycles with out_ready=1 -> q = 1,3,6,10,9, each 2 cycles after its input.
REQ-036 SHALL cover writing c = {1,2,3,4}, then impulse 1,0,0,0,0 -> q = 1,2,3,4,0.
REQ-037 SHALL cover OW=6, all c=15, x=15 streamed -> q = 63 (saturated) from the second output onward; the first output is 225, also clamped to 63.
REQ-038 SHALL cover out_ready=0 for 5 cycles mid-stream -> q/out_valid held, in_ready=0; after release the remaining sums appear in order with none dropped.
REQ-039 SHALL cover rst pulsed low with 2 samples in flight -> out_valid=0 and q=0 immediately; inputs 2,2 then give q = 2,4.
REQ-040 SHALL cover clr together with in_valid=1, and a write to coef_addr=TAPS -> sample not accepted, history zeroed, coefficients unchanged.
